tick_scheduler: RTL

Central timebase for the alarm clock. One prescaler turns the fast system clock into a base tick. From that tick, four independently programmable channels produce one-cycle enable strobes and matching square waves. Typical channel uses are seconds keeping, display blink, display scan and alarm buzzer modulation. A valid/ready write port reprograms channels at run time, and changes are applied glitch-free on base-tick boundaries. A resync input realigns all channels when the user sets the time.

---
 rtl/tick_scheduler.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/tick_scheduler.sv
// Prescaled base tick plus four programmable strobe/square channels; TICK_SCHED_FREEZE_EN adds a freeze input.
// Outputs registered; cfg_ready drops from accept until the write lands on the next base tick (or resync).
module tick_scheduler #(
    parameter int unsigned CLK_HZ   = 100000000,
    parameter int unsigned BASE_HZ  = 1000,
    parameter int unsigned DIV0_RST = 1000,
    parameter int unsigned DIV1_RST = 500,
    parameter int unsigned DIV2_RST = 1,
    parameter int unsigned DIV3_RST = 250
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cfg_valid,
    output logic        cfg_ready,
    input  logic [1:0]  cfg_ch,
    input  logic [15:0] cfg_div,
    input  logic        cfg_en,
    input  logic        resync,
`ifdef TICK_SCHED_FREEZE_EN
    input  logic        freeze,
`endif
    output logic [3:0]  tick,
    output logic [3:0]  sq,
    output logic        base_tick
);

    localparam int unsigned PRE    = CLK_HZ / BASE_HZ;
    localparam logic [31:0] PRE_M1 = 32'(PRE - 1);

    typedef enum logic {IDLE, PEND} cfg_state_t;

    cfg_state_t        state_q, state_d;
    logic [31:0]       pc_q, pc_d;
    logic              base_tick_q;
    logic [3:0][15:0]  div_q, div_d;
    logic [3:0][15:0]  cnt_q, cnt_d;
    logic [3:0]        en_q, en_d;
    logic [3:0]        tick_q, tick_d;
    logic [3:0]        sq_q, sq_d;
    logic [1:0]        pend_ch_q;
    logic [15:0]       pend_div_q;
    logic              pend_en_q;
    logic              frz;
    logic              pc_wrap;
    logic              bt;
    logic              accept;
    logic              apply;

`ifdef TICK_SCHED_FREEZE_EN
    assign frz = freeze;
`else
    assign frz = 1'b0;
`endif

    assign pc_wrap = (pc_q == PRE_M1);
    assign bt      = pc_wrap && !frz;
    assign accept  = cfg_valid && cfg_ready;
    // A pending write lands on the first real base tick, or immediately on resync.
    assign apply   = (state_q == PEND) && (bt || resync);

    always_comb begin
        pc_d = pc_q;
        if (resync) begin
            pc_d = '0;
        end else if (!frz) begin
            pc_d = pc_wrap ? '0 : pc_q + 32'd1;
        end
    end

    // Config FSM: state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Config FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (cfg_valid) state_d = PEND;
            PEND:    if (bt || resync) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Config FSM: outputs
    always_comb begin
        cfg_ready = (state_q == IDLE);
    end

    always_comb begin
        for (int c = 0; c < 4; c++) begin
            div_d[c]  = div_q[c];
            en_d[c]   = en_q[c];
            cnt_d[c]  = cnt_q[c];
            sq_d[c]   = sq_q[c];
            tick_d[c] = 1'b0;
            if (apply && (pend_ch_q == 2'(c))) begin
                // Reprogrammed channel restarts its count and skips this edge's strobe.
                div_d[c] = pend_div_q;
                en_d[c]  = pend_en_q;
                cnt_d[c] = '0;
                if (resync) sq_d[c] = 1'b0;
            end else if (resync) begin
                cnt_d[c] = '0;
                sq_d[c]  = 1'b0;
            end else if (bt) begin
                if (en_q[c] && (div_q[c] != 16'd0)) begin
                    if (cnt_q[c] == div_q[c] - 16'd1) begin
                        cnt_d[c]  = '0;
                        tick_d[c] = 1'b1;
                        sq_d[c]   = ~sq_q[c];
                    end else begin
                        cnt_d[c] = cnt_q[c] + 16'd1;
                    end
                end else begin
                    cnt_d[c] = '0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q        <= '0;
            base_tick_q <= 1'b0;
            div_q[0]    <= 16'(DIV0_RST);
            div_q[1]    <= 16'(DIV1_RST);
            div_q[2]    <= 16'(DIV2_RST);
            div_q[3]    <= 16'(DIV3_RST);
            en_q        <= 4'hF;
            cnt_q       <= '0;
            tick_q      <= '0;
            sq_q        <= '0;
            pend_ch_q   <= '0;
            pend_div_q  <= '0;
            pend_en_q   <= 1'b0;
        end else begin
            pc_q        <= pc_d;
            base_tick_q <= bt && !resync;
            div_q       <= div_d;
            en_q        <= en_d;
            cnt_q       <= cnt_d;
            tick_q      <= tick_d;
            sq_q        <= sq_d;
            if (accept) begin
                pend_ch_q  <= cfg_ch;
                pend_div_q <= cfg_div;
                pend_en_q  <= cfg_en;
            end
        end
    end

    assign tick      = tick_q;
    assign sq        = sq_q;
    assign base_tick = base_tick_q;

endmodule
